// File: rtl/dual_lane_name_scheduler_if.sv
// Requester handshake, pipeline hold and dual issue-lane bus of the
// dual-lane name scheduler. The master side offers names and consumes lane
// words; the slave side is the scheduler itself.
interface dual_lane_name_scheduler_if #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int LEN_SIZE        = 4,
  parameter int IDX_SIZE        = 3
);
  localparam int NAME_W = WORD_SIZE * MAX_NAME_LENGTH;

  logic                 req_valid_0_in;
  logic [NAME_W-1:0]    req_name_0_in;
  logic [LEN_SIZE-1:0]  req_len_0_in;
  logic                 req_ready_0_out;
  logic                 req_valid_1_in;
  logic [NAME_W-1:0]    req_name_1_in;
  logic [LEN_SIZE-1:0]  req_len_1_in;
  logic                 req_ready_1_out;
  logic                 stall_in;
  logic                 lane_valid_1_out;
  logic [WORD_SIZE-1:0] lane_word_1_out;
  logic [IDX_SIZE-1:0]  lane_idx_1_out;
  logic                 lane_last_1_out;
  logic                 lane_tag_1_out;
  logic                 lane_valid_2_out;
  logic [WORD_SIZE-1:0] lane_word_2_out;
  logic [IDX_SIZE-1:0]  lane_idx_2_out;
  logic                 lane_last_2_out;
  logic                 lane_tag_2_out;

  modport master (
    output req_valid_0_in, req_name_0_in, req_len_0_in,
    output req_valid_1_in, req_name_1_in, req_len_1_in,
    output stall_in,
    input  req_ready_0_out, req_ready_1_out,
    input  lane_valid_1_out, lane_word_1_out, lane_idx_1_out, lane_last_1_out, lane_tag_1_out,
    input  lane_valid_2_out, lane_word_2_out, lane_idx_2_out, lane_last_2_out, lane_tag_2_out
  );

  modport slave (
    input  req_valid_0_in, req_name_0_in, req_len_0_in,
    input  req_valid_1_in, req_name_1_in, req_len_1_in,
    input  stall_in,
    output req_ready_0_out, req_ready_1_out,
    output lane_valid_1_out, lane_word_1_out, lane_idx_1_out, lane_last_1_out, lane_tag_1_out,
    output lane_valid_2_out, lane_word_2_out, lane_idx_2_out, lane_last_2_out, lane_tag_2_out
  );
endinterface

// File: rtl/dual_lane_name_scheduler.sv
// Round-robin issue scheduler: two requesters each hand over a whole name,
// which is assigned to a free issue lane and streamed out one word per cycle.
// Index 0 of every internal lane array is lane 1, index 1 is lane 2.
module dual_lane_name_scheduler #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int LEN_SIZE        = 4,
  parameter int IDX_SIZE        = 3
) (
  input logic                      clk_in,
  input logic                      rst_n_in,
  dual_lane_name_scheduler_if.slave bus
);
  localparam int NAME_W = WORD_SIZE * MAX_NAME_LENGTH;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  // Effective length minus one: zero length counts as one word, long names clamp.
  function automatic logic [LEN_SIZE-1:0] eff_len_m1(input logic [LEN_SIZE-1:0] len);
    if (len == '0) return '0;
    if (len > LEN_SIZE'(MAX_NAME_LENGTH)) return LEN_SIZE'(MAX_NAME_LENGTH - 1);
    return len - LEN_SIZE'(1);
  endfunction

  function automatic logic [WORD_SIZE-1:0] word_at(input logic [NAME_W-1:0] name,
                                                   input logic [IDX_SIZE-1:0] idx);
    return name[idx*WORD_SIZE +: WORD_SIZE];
  endfunction

  logic                 w_stall;
  logic [1:0]           w_req_valid;
  logic [NAME_W-1:0]    w_req_name [2];
  logic [LEN_SIZE-1:0]  w_req_len  [2];

  state_t               r_state [2];
  logic [NAME_W-1:0]    r_name  [2];
  logic [LEN_SIZE-1:0]  r_lm1   [2];
  logic [IDX_SIZE-1:0]  r_idx   [2];
  logic [WORD_SIZE-1:0] r_word  [2];
  logic                 r_last  [2];
  logic                 r_tag   [2];
  logic                 r_ptr;

  logic [1:0]           w_free;
  logic [1:0]           w_gnt;     // per requester
  logic [1:0]           w_load;    // per lane
  logic [1:0]           w_sel;     // per lane: requester being loaded
  logic                 w_contend;
  logic [IDX_SIZE-1:0]  w_nidx    [2];
  logic [LEN_SIZE-1:0]  w_load_lm1 [2];

  assign w_stall       = bus.stall_in;
  assign w_req_valid   = {bus.req_valid_1_in, bus.req_valid_0_in};
  assign w_req_name[0] = bus.req_name_0_in;
  assign w_req_name[1] = bus.req_name_1_in;
  assign w_req_len[0]  = bus.req_len_0_in;
  assign w_req_len[1]  = bus.req_len_1_in;

  // Per-lane freeness, next index and the length of the name about to be loaded.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      w_free[l]     = (r_state[l] == ST_IDLE) || (r_last[l] && !w_stall);
      w_nidx[l]     = r_idx[l] + IDX_SIZE'(1);
      w_load_lm1[l] = eff_len_m1(w_req_len[w_sel[l]]);
    end
  end

  // Grant arbitration: fixed pairing when both lanes are free, lowest free lane
  // for a single requester, round-robin pointer when two requesters share one lane.
  always_comb begin
    w_gnt     = '0;
    w_load    = '0;
    w_sel     = '0;
    w_contend = 1'b0;
    if (rst_n_in && !w_stall) begin
      if (&w_req_valid) begin
        if (&w_free) begin
          w_gnt  = 2'b11;
          w_load = 2'b11;
          w_sel  = 2'b10;
        end else if (|w_free) begin
          w_contend    = 1'b1;
          w_gnt[r_ptr] = 1'b1;
          w_load       = w_free;
          w_sel        = {2{r_ptr}};
        end
      end else if (|w_req_valid) begin
        w_sel = {2{w_req_valid[1]}};
        if (w_free[0]) begin
          w_gnt  = w_req_valid;
          w_load = 2'b01;
        end else if (w_free[1]) begin
          w_gnt  = w_req_valid;
          w_load = 2'b10;
        end
      end
    end
  end

  assign bus.req_ready_0_out = w_gnt[0];
  assign bus.req_ready_1_out = w_gnt[1];

  // Round-robin pointer flips only after a contended grant.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)      r_ptr <= 1'b0;
    else if (w_contend) r_ptr <= ~r_ptr;
  end

  // Name storage; contents are irrelevant while a lane is idle.
  always_ff @(posedge clk_in) begin
    for (int l = 0; l < 2; l++)
      if (!w_stall && w_load[l]) r_name[l] <= w_req_name[w_sel[l]];
  end

  // Lane FSMs with registered word/index/last/tag outputs, zeroed while idle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int l = 0; l < 2; l++) begin
        r_state[l] <= ST_IDLE;
        r_lm1[l]   <= '0;
        r_idx[l]   <= '0;
        r_word[l]  <= '0;
        r_last[l]  <= 1'b0;
        r_tag[l]   <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int l = 0; l < 2; l++) begin
        if (w_load[l]) begin
          r_state[l] <= ST_ISSUE;
          r_lm1[l]   <= w_load_lm1[l];
          r_idx[l]   <= '0;
          r_word[l]  <= w_req_name[w_sel[l]][WORD_SIZE-1:0];
          r_last[l]  <= (w_load_lm1[l] == '0);
          r_tag[l]   <= w_sel[l];
        end else if (r_state[l] == ST_ISSUE) begin
          if (r_last[l]) begin
            r_state[l] <= ST_IDLE;
            r_lm1[l]   <= '0;
            r_idx[l]   <= '0;
            r_word[l]  <= '0;
            r_last[l]  <= 1'b0;
            r_tag[l]   <= 1'b0;
          end else begin
            r_idx[l]  <= w_nidx[l];
            r_word[l] <= word_at(r_name[l], w_nidx[l]);
            r_last[l] <= (LEN_SIZE'(w_nidx[l]) == r_lm1[l]);
          end
        end
      end
    end
  end

  assign bus.lane_valid_1_out = (r_state[0] == ST_ISSUE);
  assign bus.lane_word_1_out  = r_word[0];
  assign bus.lane_idx_1_out   = r_idx[0];
  assign bus.lane_last_1_out  = r_last[0];
  assign bus.lane_tag_1_out   = r_tag[0];
  assign bus.lane_valid_2_out = (r_state[1] == ST_ISSUE);
  assign bus.lane_word_2_out  = r_word[1];
  assign bus.lane_idx_2_out   = r_idx[1];
  assign bus.lane_last_2_out  = r_last[1];
  assign bus.lane_tag_2_out   = r_tag[1];
endmodule
